// File: rtl/score_keeper.sv
// Score keeper: BCD running score, fish/boot catch counts and session high score.
// Rising levels on scoreUp/scoreDown are counted once; all outputs are registered.
module score_keeper #(
  parameter logic [7:0] MAX_SCORE = 8'h99,
  parameter logic [7:0] HIGH_INIT = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scoreUp,
  input  logic       scoreDown,
  input  logic       scoreRst,
  output logic [7:0] currentScore,
  output logic [7:0] highScore,
  output logic [7:0] fishCount,
  output logic [7:0] bootCount,
  output logic       newHigh,
  output logic       scoreEvent
);

  logic [7:0] score_q, score_d;
  logic [7:0] fish_q, fish_d;
  logic [7:0] boot_q, boot_d;
  logic [7:0] high_q, high_d;
  logic       new_high_q, new_high_d;
  logic       event_q, event_d;
  logic       up_prev_q, down_prev_q;
  logic       up_edge, down_edge;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v >= MAX_SCORE) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00) return v;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign up_edge   = scoreUp & ~up_prev_q;
  assign down_edge = scoreDown & ~down_prev_q;

  always_comb begin
    score_d    = score_q;
    fish_d     = fish_q;
    boot_d     = boot_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    if (scoreRst) begin
      score_d    = 8'h00;
      fish_d     = 8'h00;
      boot_d     = 8'h00;
      new_high_d = 1'b0;
    end else begin
      if (up_edge)   fish_d = bcd_inc(fish_q);
      if (down_edge) boot_d = bcd_inc(boot_q);
      if (up_edge && !down_edge)      score_d = bcd_inc(score_q);
      else if (down_edge && !up_edge) score_d = bcd_dec(score_q);
    end
    // Valid BCD orders the same as binary, so a plain compare works.
    if (score_d > high_q) begin
      high_d     = score_d;
      new_high_d = 1'b1;
    end
    event_d = (score_d != score_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      score_q     <= 8'h00;
      fish_q      <= 8'h00;
      boot_q      <= 8'h00;
      high_q      <= HIGH_INIT;
      new_high_q  <= 1'b0;
      event_q     <= 1'b0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      fish_q      <= fish_d;
      boot_q      <= boot_d;
      high_q      <= high_d;
      new_high_q  <= new_high_d;
      event_q     <= event_d;
      up_prev_q   <= scoreUp;
      down_prev_q <= scoreDown;
    end
  end

  assign currentScore = score_q;
  assign highScore    = high_q;
  assign fishCount    = fish_q;
  assign bootCount    = boot_q;
  assign newHigh      = new_high_q;
  assign scoreEvent   = event_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus randomized levels against an integer model.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst_n, up, down, srst;
  logic [7:0] cur_score, high_score, fish_cnt, boot_cnt;
  logic       new_high, score_ev;

  int n_cmp = 0;
  int n_fail = 0;
  int ev_seen = 0;

  // Reference model: plain integers, converted to BCD only for comparison.
  int m_score, m_fish, m_boot, m_high;
  bit m_nh, m_ev, m_pu, m_pd;

  always #10 clk = ~clk;

  score_keeper #(.MAX_SCORE(8'h99), .HIGH_INIT(8'h00)) dut (
    .CLK(clk), .RST(rst_n), .scoreUp(up), .scoreDown(down), .scoreRst(srst),
    .currentScore(cur_score), .highScore(high_score), .fishCount(fish_cnt),
    .bootCount(boot_cnt), .newHigh(new_high), .scoreEvent(score_ev)
  );

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic tick(input bit r, input bit u, input bit d, input bit s);
    bit ue, de;
    int old;
    rst_n = r; up = u; down = d; srst = s;
    @(posedge clk);
    if (!r) begin
      m_score = 0; m_fish = 0; m_boot = 0; m_high = 0;
      m_nh = 0; m_ev = 0; m_pu = 0; m_pd = 0;
    end else begin
      ue = u && !m_pu;
      de = d && !m_pd;
      m_pu = u;
      m_pd = d;
      old = m_score;
      if (s) begin
        m_score = 0; m_fish = 0; m_boot = 0; m_nh = 0;
      end else begin
        if (ue) m_fish = (m_fish < 99) ? m_fish + 1 : 99;
        if (de) m_boot = (m_boot < 99) ? m_boot + 1 : 99;
        if (ue && !de)      m_score = (m_score < 99) ? m_score + 1 : 99;
        else if (de && !ue) m_score = (m_score > 0) ? m_score - 1 : 0;
      end
      if (m_score > m_high) begin
        m_high = m_score;
        m_nh = 1;
      end
      m_ev = (m_score != old);
    end
    #1;
    if (score_ev === 1'b1) ev_seen++;
  endtask

  task automatic pulse_up(input int n);
    repeat (n) begin tick(1, 1, 0, 0); tick(1, 0, 0, 0); end
  endtask

  task automatic pulse_down(input int n);
    repeat (n) begin tick(1, 0, 1, 0); tick(1, 0, 0, 0); end
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    n_cmp++;
    if ({cur_score, high_score, fish_cnt, boot_cnt} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values got %h %h %h %h want 00 00 00 00", cur_score, high_score, fish_cnt, boot_cnt);
    end
    n_cmp++;
    if ({new_high, score_ev} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags got nh=%b ev=%b want 0 0", new_high, score_ev);
    end
  endtask

  task automatic test_pulses();
    tick(1, 0, 0, 0);
    ev_seen = 0;
    pulse_up(12);
    n_cmp++;
    if ({cur_score, fish_cnt, high_score} !== 24'h121212) begin
      n_fail++;
      $display("FAIL pulse12_values got %h %h %h want 12 12 12", cur_score, fish_cnt, high_score);
    end
    n_cmp++;
    if (new_high !== 1'b1) begin n_fail++; $display("FAIL pulse12_newhigh got %b want 1", new_high); end
    n_cmp++;
    if (ev_seen != 12) begin n_fail++; $display("FAIL pulse12_events got %0d want 12", ev_seen); end
  endtask

  task automatic test_held_level();
    tick(1, 0, 0, 1);
    pulse_up(9);
    ev_seen = 0;
    repeat (20) tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    n_cmp++;
    if (cur_score !== 8'h10) begin n_fail++; $display("FAIL held_carry got %h want 10", cur_score); end
    n_cmp++;
    if (ev_seen != 1) begin n_fail++; $display("FAIL held_events got %0d want 1", ev_seen); end
  endtask

  task automatic test_down_floor();
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 0);
    ev_seen = 0;
    pulse_down(3);
    n_cmp++;
    if ({cur_score, boot_cnt} !== 16'h0003) begin
      n_fail++;
      $display("FAIL floor_values got %h %h want 00 03", cur_score, boot_cnt);
    end
    n_cmp++;
    if (ev_seen != 0) begin n_fail++; $display("FAIL floor_events got %0d want 0", ev_seen); end
    pulse_up(10);
    pulse_down(1);
    n_cmp++;
    if (cur_score !== 8'h09) begin n_fail++; $display("FAIL borrow got %h want 09", cur_score); end
  endtask

  task automatic test_saturate_and_both();
    tick(1, 0, 0, 1);
    pulse_up(99);
    tick(1, 1, 0, 0);
    n_cmp++;
    if ({cur_score, fish_cnt, score_ev} !== {8'h99, to_bcd(m_fish), 1'b0}) begin
      n_fail++;
      $display("FAIL saturate got %h %h ev=%b want 99 %h ev=0", cur_score, fish_cnt, score_ev, to_bcd(m_fish));
    end
    tick(1, 0, 0, 1);
    pulse_up(45);
    tick(1, 1, 1, 0);
    n_cmp++;
    if ({cur_score, fish_cnt, boot_cnt, score_ev} !== {8'h45, 8'h46, 8'h01, 1'b0}) begin
      n_fail++;
      $display("FAIL both_edges got %h %h %h ev=%b want 45 46 01 ev=0", cur_score, fish_cnt, boot_cnt, score_ev);
    end
    tick(1, 0, 0, 0);
  endtask

  task automatic test_scorerst_high();
    tick(0, 0, 0, 0);
    pulse_up(12);
    tick(1, 0, 0, 1);
    n_cmp++;
    if ({cur_score, fish_cnt, boot_cnt, high_score, new_high, score_ev} !== {32'h00000012, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL scorerst got %h %h %h %h nh=%b ev=%b want 00 00 00 12 nh=0 ev=1",
               cur_score, fish_cnt, boot_cnt, high_score, new_high, score_ev);
    end
    tick(1, 0, 0, 0);
    pulse_up(12);
    n_cmp++;
    if ({high_score, new_high} !== {8'h12, 1'b0}) begin
      n_fail++;
      $display("FAIL tie_high got %h nh=%b want 12 nh=0", high_score, new_high);
    end
    pulse_up(1);
    n_cmp++;
    if ({high_score, new_high} !== {8'h13, 1'b1}) begin
      n_fail++;
      $display("FAIL beat_high got %h nh=%b want 13 nh=1", high_score, new_high);
    end
  endtask

  task automatic test_up_across_rst();
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(1, 1, 0, 0);
    n_cmp++;
    if (cur_score !== 8'h01) begin n_fail++; $display("FAIL rst_release_count got %h want 01", cur_score); end
    repeat (5) tick(1, 1, 0, 0);
    n_cmp++;
    if (cur_score !== 8'h01) begin n_fail++; $display("FAIL rst_release_hold got %h want 01", cur_score); end
    tick(1, 0, 0, 0);
  endtask

  task automatic test_random();
    int pu, pd;
    bit r, s;
    for (int i = 0; i < 4000; i++) begin
      pu = (i % 1000 < 600) ? 70 : 30;
      pd = (i % 1000 < 600) ? 20 : 60;
      r  = ($urandom_range(0, 599) != 0);
      s  = ($urandom_range(0, 149) == 0);
      tick(r, $urandom_range(0, 99) < pu, $urandom_range(0, 99) < pd, s);
      n_cmp++;
      if ({cur_score, high_score, fish_cnt, boot_cnt, new_high, score_ev} !==
          {to_bcd(m_score), to_bcd(m_high), to_bcd(m_fish), to_bcd(m_boot), m_nh, m_ev}) begin
        n_fail++;
        $display("FAIL random[%0d] got %h %h %h %h nh=%b ev=%b want %h %h %h %h nh=%b ev=%b", i,
                 cur_score, high_score, fish_cnt, boot_cnt, new_high, score_ev,
                 to_bcd(m_score), to_bcd(m_high), to_bcd(m_fish), to_bcd(m_boot), m_nh, m_ev);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; up = 1'b0; down = 1'b0; srst = 1'b0;
    test_reset();
    test_pulses();
    test_held_level();
    test_down_floor();
    test_saturate_and_both();
    test_scorerst_high();
    test_up_across_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
